// File: rtl/dl_rom_writer.sv
// dl_rom_writer: takes the loader byte stream over a valid/ready handshake,
// keeps a running download address and turns each accepted byte into a
// one-cycle write on one of four ROM region ports.
// Optional feature macro: DL_CHECKSUM_EN builds the 16-bit additive checksum
// on dl_sum. When it is undefined, dl_sum is tied to zero.
module dl_rom_writer #(
    parameter int          AW      = 16,
    parameter int unsigned R0_BASE = 32'h0000,
    parameter int          R0_AW   = 14,
    parameter int unsigned R1_BASE = 32'h4000,
    parameter int          R1_AW   = 12,
    parameter int unsigned R2_BASE = 32'h5000,
    parameter int          R2_AW   = 12,
    parameter int unsigned R3_BASE = 32'h6000,
    parameter int          R3_AW   = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dl_en,
    input  logic          dl_valid,
    input  logic [7:0]    dl_data,
    output logic          dl_ready,
    output logic [AW-1:0] rom_ad,
    output logic [7:0]    rom_di,
    output logic [3:0]    rom_we,
    output logic          dl_done,
    output logic          dl_ovf,
    output logic [15:0]   dl_sum
);

    typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

    // Region windows as half-open [lo, hi) ranges, one bit wider than the
    // download address so that the upper bound never wraps.
    localparam logic [32:0] R0_LO = 33'(R0_BASE);
    localparam logic [32:0] R0_HI = R0_LO + (33'd1 << R0_AW);
    localparam logic [32:0] R1_LO = 33'(R1_BASE);
    localparam logic [32:0] R1_HI = R1_LO + (33'd1 << R1_AW);
    localparam logic [32:0] R2_LO = 33'(R2_BASE);
    localparam logic [32:0] R2_HI = R2_LO + (33'd1 << R2_AW);
    localparam logic [32:0] R3_LO = 33'(R3_BASE);
    localparam logic [32:0] R3_HI = R3_LO + (33'd1 << R3_AW);

    // Bases truncated to the address width; the offset subtraction only
    // needs the low AW bits.
    localparam logic [AW-1:0] B0 = AW'(R0_BASE);
    localparam logic [AW-1:0] B1 = AW'(R1_BASE);
    localparam logic [AW-1:0] B2 = AW'(R2_BASE);
    localparam logic [AW-1:0] B3 = AW'(R3_BASE);

    state_t        state;
    logic          dl_en_q;
    logic [AW-1:0] addr;
    logic          past_end;
    logic [32:0]   addr_ext;
    logic [3:0]    hit;
    logic [AW-1:0] base_sel;
    logic [AW-1:0] offset;
    logic          start_session;

    assign addr_ext      = 33'(addr);
    assign offset        = addr - base_sel;
    assign start_session = dl_en & ~dl_en_q & ((state == IDLE) | (state == DONE));

    // Region decode of the current address; the lowest region wins on overlap.
    always_comb begin
        hit      = 4'b0000;
        base_sel = '0;
        if (addr_ext >= R0_LO && addr_ext < R0_HI) begin
            hit      = 4'b0001;
            base_sel = B0;
        end else if (addr_ext >= R1_LO && addr_ext < R1_HI) begin
            hit      = 4'b0010;
            base_sel = B1;
        end else if (addr_ext >= R2_LO && addr_ext < R2_HI) begin
            hit      = 4'b0100;
            base_sel = B2;
        end else if (addr_ext >= R3_LO && addr_ext < R3_HI) begin
            hit      = 4'b1000;
            base_sel = B3;
        end
    end

    // Session FSM: accept a byte in RUN, pulse the write in WRITE, then advance
    // the address (saturating with a sticky past-end flag at the top).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dl_en_q  <= 1'b0;
            addr     <= '0;
            past_end <= 1'b0;
            dl_ready <= 1'b0;
            rom_ad   <= '0;
            rom_di   <= 8'h00;
            rom_we   <= 4'b0000;
            dl_done  <= 1'b0;
            dl_ovf   <= 1'b0;
        end else begin
            dl_en_q <= dl_en;
            case (state)
                IDLE, DONE: begin
                    if (start_session) begin
                        addr     <= '0;
                        past_end <= 1'b0;
                        dl_ovf   <= 1'b0;
                        dl_done  <= 1'b0;
                        dl_ready <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (dl_valid) begin
                        rom_di   <= dl_data;
                        rom_ad   <= offset;
                        dl_ready <= 1'b0;
                        state    <= WRITE;
                        if (past_end) begin
                            dl_ovf <= 1'b1;
                        end else begin
                            rom_we <= hit;
                        end
                    end else if (!dl_en) begin
                        dl_ready <= 1'b0;
                        dl_done  <= 1'b1;
                        state    <= DONE;
                    end
                end
                WRITE: begin
                    rom_we <= 4'b0000;
                    if (!past_end) begin
                        if (&addr) begin
                            past_end <= 1'b1;
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                    if (dl_en) begin
                        dl_ready <= 1'b1;
                        state    <= RUN;
                    end else begin
                        dl_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running checksum of every accepted byte, folded in during the write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 16'h0000;
        end else if (start_session) begin
            sum_q <= 16'h0000;
        end else if (state == WRITE) begin
            sum_q <= sum_q + {8'h00, rom_di};
        end
    end

    assign dl_sum = sum_q;
`else
    assign dl_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_dl_rom_writer.sv
// Testbench for dl_rom_writer. Three instances share one loader stream:
// the default map, a 4-bit address space with the default map, and a
// 4-bit space with small overlapping regions and an unmapped gap.
module tb_dl_rom_writer;

    localparam int NDUT = 3;
    localparam int unsigned AWS   [NDUT]    = '{16, 4, 4};
    localparam int unsigned BASES [NDUT][4] = '{'{32'h0000, 32'h4000, 32'h5000, 32'h6000},
                                                '{32'h0000, 32'h4000, 32'h5000, 32'h6000},
                                                '{32'd0, 32'd4, 32'd8, 32'd9}};
    localparam int unsigned SIZES [NDUT][4] = '{'{14, 12, 12, 13},
                                                '{14, 12, 12, 13},
                                                '{2, 2, 1, 2}};

    logic        clk;
    logic        rst_n;
    logic        dl_en;
    logic        dl_valid;
    logic [7:0]  dl_data;

    logic        readyA [NDUT];
    logic [3:0]  weA    [NDUT];
    logic [7:0]  diA    [NDUT];
    logic        doneA  [NDUT];
    logic        ovfA   [NDUT];
    logic [15:0] sumA   [NDUT];
    logic [15:0] ad0;
    logic [3:0]  ad1;
    logic [3:0]  ad2;

    int          total = 0;
    int          bad   = 0;
    int unsigned cnt   = 0;
    int unsigned modelSum = 0;
    int          waits;

    dl_rom_writer #(.AW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .dl_en(dl_en), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(readyA[0]), .rom_ad(ad0), .rom_di(diA[0]), .rom_we(weA[0]),
        .dl_done(doneA[0]), .dl_ovf(ovfA[0]), .dl_sum(sumA[0])
    );

    dl_rom_writer #(.AW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .dl_en(dl_en), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(readyA[1]), .rom_ad(ad1), .rom_di(diA[1]), .rom_we(weA[1]),
        .dl_done(doneA[1]), .dl_ovf(ovfA[1]), .dl_sum(sumA[1])
    );

    dl_rom_writer #(
        .AW(4),
        .R0_BASE(32'd0), .R0_AW(2),
        .R1_BASE(32'd4), .R1_AW(2),
        .R2_BASE(32'd8), .R2_AW(1),
        .R3_BASE(32'd9), .R3_AW(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .dl_en(dl_en), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(readyA[2]), .rom_ad(ad2), .rom_di(diA[2]), .rom_we(weA[2]),
        .dl_done(doneA[2]), .dl_ovf(ovfA[2]), .dl_sum(sumA[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never returns
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] adOf(input int d);
        case (d)
            0:       return ad0;
            1:       return {12'h000, ad1};
            default: return {12'h000, ad2};
        endcase
    endfunction

    // Expected one-hot write enable for session byte number n
    function automatic logic [3:0] expWe(input int d, input int unsigned n);
        if (n >= (32'd1 << AWS[d])) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (n >= BASES[d][k] && n < BASES[d][k] + (32'd1 << SIZES[d][k]))
                return 4'(1 << k);
        end
        return 4'b0000;
    endfunction

    // Expected offset within the winning region for session byte number n
    function automatic int unsigned expAd(input int d, input int unsigned n);
        for (int k = 0; k < 4; k++) begin
            if (n >= BASES[d][k] && n < BASES[d][k] + (32'd1 << SIZES[d][k]))
                return n - BASES[d][k];
        end
        return 0;
    endfunction

    function automatic logic [15:0] expSum();
`ifdef DL_CHECKSUM_EN
        return modelSum[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string tag, input int d, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, d, obs, want);
        end
    endtask

    task automatic checkReset(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput({tag, "_ready"}, d, 32'(readyA[d]), 32'd0);
            checkOutput({tag, "_we"},    d, 32'(weA[d]),    32'd0);
            checkOutput({tag, "_ad"},    d, 32'(adOf(d)),   32'd0);
            checkOutput({tag, "_di"},    d, 32'(diA[d]),    32'd0);
            checkOutput({tag, "_done"},  d, 32'(doneA[d]),  32'd0);
            checkOutput({tag, "_ovf"},   d, 32'(ovfA[d]),   32'd0);
            checkOutput({tag, "_sum"},   d, 32'(sumA[d]),   32'd0);
        end
    endtask

    // Raise dl_en (called on a negedge with dl_en low) and land in RUN
    task automatic startSession();
        dl_en    = 1'b1;
        dl_valid = 1'b0;
        @(negedge clk);
        cnt      = 0;
        modelSum = 0;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("start_ready", d, 32'(readyA[d]), 32'd1);
            checkOutput("start_done",  d, 32'(doneA[d]),  32'd0);
            checkOutput("start_ovf",   d, 32'(ovfA[d]),   32'd0);
        end
    endtask

    // Drop dl_en and check the session settles into DONE
    task automatic endSession();
        dl_en    = 1'b0;
        dl_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("end_done",  d, 32'(doneA[d]),  32'd1);
            checkOutput("end_ready", d, 32'(readyA[d]), 32'd0);
            checkOutput("end_sum",   d, 32'(sumA[d]),   32'(expSum()));
        end
        @(negedge clk);
    endtask

    // Offer one byte, wait (bounded) for acceptance and check the write cycle.
    // Returns on the negedge inside the write cycle with dl_valid still high.
    task automatic applyStimulus(input logic [7:0] b, output int nWait);
        dl_valid = 1'b1;
        dl_data  = b;
        nWait    = 0;
        while (readyA[0] !== 1'b1 && nWait < 6) begin
            @(negedge clk);
            nWait++;
        end
        if (readyA[0] !== 1'b1) begin
            total++;
            bad++;
            $error("FAIL ready_timeout dut0: observed=%0h expected=1", readyA[0]);
            dl_valid = 1'b0;
            return;
        end
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("run_ready", d, 32'(readyA[d]), 32'd1);
            checkOutput("run_done",  d, 32'(doneA[d]),  32'd0);
            checkOutput("run_sum",   d, 32'(sumA[d]),   32'(expSum()));
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            logic [3:0] ew;
            ew = expWe(d, cnt);
            checkOutput("wr_we",    d, 32'(weA[d]),    32'(ew));
            checkOutput("wr_di",    d, 32'(diA[d]),    32'(b));
            checkOutput("wr_ready", d, 32'(readyA[d]), 32'd0);
            checkOutput("wr_ovf",   d, 32'(ovfA[d]),   32'(cnt >= (32'd1 << AWS[d])));
            if (ew != 4'b0000)
                checkOutput("wr_ad", d, 32'(adOf(d)), expAd(d, cnt));
        end
        cnt++;
        modelSum = modelSum + 32'(b);
    endtask

    // Directed sequence
    initial begin
        rst_n    = 1'b0;
        dl_en    = 1'b0;
        dl_valid = 1'b0;
        dl_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset values");
        checkReset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        checkReset("idle");

        $display("[TB] three-byte stream with valid held high");
        startSession();
        applyStimulus(8'h11, waits);
        checkOutput("first_wait", 0, 32'(waits), 32'd0);
        checkOutput("b0_we", 0, 32'(weA[0]), 32'h1);
        checkOutput("b0_ad", 0, 32'(ad0), 32'h0);
        applyStimulus(8'h22, waits);
        checkOutput("ready_toggle", 0, 32'(waits), 32'd1);
        checkOutput("b1_ad", 0, 32'(ad0), 32'h1);
        applyStimulus(8'h33, waits);
        checkOutput("ready_toggle", 0, 32'(waits), 32'd1);
        checkOutput("b2_we", 0, 32'(weA[0]), 32'h1);
        checkOutput("b2_ad", 0, 32'(ad0), 32'h2);
        endSession();
`ifdef DL_CHECKSUM_EN
        checkOutput("sum_0x66", 0, 32'(sumA[0]), 32'h0066);
`else
        checkOutput("sum_tied", 0, 32'(sumA[0]), 32'h0000);
`endif

        $display("[TB] random session past the 4-bit address space");
        startSession();
        for (int i = 0; i < 20; i++) begin
            int gap;
            applyStimulus(8'($urandom), waits);
            if (i == 15) begin
                checkOutput("aw4_last_we", 1, 32'(weA[1]), 32'h1);
                checkOutput("aw4_last_ad", 1, 32'(ad1), 32'hF);
                checkOutput("aw4_last_ovf", 1, 32'(ovfA[1]), 32'd0);
            end
            if (i == 16) begin
                checkOutput("aw4_ovf_we", 1, 32'(weA[1]), 32'h0);
                checkOutput("aw4_ovf", 1, 32'(ovfA[1]), 32'd1);
            end
            if (i == 9) begin
                checkOutput("overlap_we", 2, 32'(weA[2]), 32'h4);
                checkOutput("overlap_ad", 2, 32'(ad2), 32'h1);
            end
            if (i == 13)
                checkOutput("gap_we", 2, 32'(weA[2]), 32'h0);
            gap = int'($urandom_range(0, 2));
            if (gap != 0) begin
                dl_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        endSession();
        checkOutput("ovf_held", 1, 32'(ovfA[1]), 32'd1);
        checkOutput("ovf_clear_wide", 0, 32'(ovfA[0]), 32'd0);

        $display("[TB] dl_en dropped during the write cycle");
        startSession();
        applyStimulus(8'hA5, waits);
        dl_en    = 1'b0;
        dl_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("drop_done",  d, 32'(doneA[d]),  32'd1);
            checkOutput("drop_ready", d, 32'(readyA[d]), 32'd0);
            checkOutput("drop_we",    d, 32'(weA[d]),    32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("drop_ready2", d, 32'(readyA[d]), 32'd0);
            checkOutput("drop_sum",    d, 32'(sumA[d]),   32'(expSum()));
        end

        $display("[TB] restart after done begins at offset zero");
        startSession();
        applyStimulus(8'h5A, waits);
        checkOutput("restart_ad", 0, 32'(ad0), 32'h0);
        checkOutput("restart_we", 0, 32'(weA[0]), 32'h1);
        endSession();

        $display("[TB] long stream into region 1");
        startSession();
        for (int i = 0; i < 32'h4004; i++) begin
            applyStimulus(8'($urandom), waits);
            if (i > 0)
                checkOutput("stream_wait", 0, 32'(waits), 32'd1);
            if (i == 32'h3FFF) begin
                checkOutput("r0_end_we", 0, 32'(weA[0]), 32'h1);
                checkOutput("r0_end_ad", 0, 32'(ad0), 32'h3FFF);
            end
            if (i == 32'h4000) begin
                checkOutput("r1_base_we", 0, 32'(weA[0]), 32'h2);
                checkOutput("r1_base_ad", 0, 32'(ad0), 32'h0);
            end
        end
        endSession();

        $display("[TB] reset pulse in the middle of a write");
        startSession();
        applyStimulus(8'h01, waits);
        applyStimulus(8'h02, waits);
        checkOutput("pre_rst_we", 0, 32'(weA[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++)
            checkOutput("async_we", d, 32'(weA[d]), 32'd0);
        checkReset("midrst");
        dl_en    = 1'b0;
        dl_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkReset("postrst");
        startSession();
        applyStimulus(8'h77, waits);
        checkOutput("post_rst_ad", 0, 32'(ad0), 32'h0);
        checkOutput("post_rst_we", 0, 32'(weA[0]), 32'h1);
        endSession();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dl_rom_writer.md
# dl_rom_writer

Download-side writer for the game's loadable ROM arrays. It accepts the byte stream from the platform loader over a valid/ready handshake and keeps a running download address. It decodes that address into one of four ROM regions and drives each region's write port (address, data, write enable), one byte per write. It sits between the top-level loader interface and the write ports of the program, character and sprite ROM blocks.

## Interface
- AW, 16: width of the download byte address (download space is 2**AW bytes)
- R0_BASE, 16'h0000: first download address of region 0
- R0_AW, 14: region 0 size is 2**R0_AW bytes
- R1_BASE, 16'h4000 / R1_AW, 12: region 1 base and size exponent
- R2_BASE, 16'h5000 / R2_AW, 12: region 2 base and size exponent
- R3_BASE, 16'h6000 / R3_AW, 13: region 3 base and size exponent

- CLK  in  1  single clock; all logic rising-edge
- RST_N  in  1  asynchronous, active-low reset
- DL_EN  in  1  download session active (level)
- DL_VALID  in  1  DL_DATA holds a byte
- DL_DATA  in  8  download byte
- DL_READY  out  1  writer can accept a byte this cycle
- ROM_AD  out  AW  byte offset within the selected region (download address minus region base, zero-extended)
- ROM_DI  out  8  write data
- ROM_WE  out  4  one-hot write enable, bit k selects region k
- DL_DONE  out  1  session finished; held until the next session starts
- DL_OVF  out  1  at least one byte arrived beyond address 2**AW-1 in this session
- DL_SUM  out  16  additive checksum (see Configuration)

## Operation
- States: IDLE, RUN, WRITE, DONE.
- IDLE: DL_READY=0. A rising DL_EN (previous sample 0, current 1) clears the address counter, DL_OVF, DL_DONE and DL_SUM, then moves to RUN.
- RUN: DL_READY=1. A byte is accepted when DL_VALID & DL_READY:
  - register ROM_DI=DL_DATA and ROM_AD=addr-base of the matching region;
  - set the matching ROM_WE bit and go to WRITE.
- WRITE: DL_READY=0 and ROM_WE is high for exactly this cycle. The address counter increments by 1. The state returns to RUN, or to DONE if DL_EN=0.
- RUN with DL_EN=0: go to DONE, set DL_DONE=1.
- DONE: DL_READY=0 and DL_DONE=1. A new rising DL_EN restarts the session as from IDLE.
- Region match: addr in [Rk_BASE, Rk_BASE+2**Rk_AW). When regions overlap, the lowest k wins.
- A byte that matches no region is accepted and counted, but ROM_WE stays 0.
- Counter overflow: a byte accepted when the counter equals 2**AW-1 is the last one that can address anything. After it, the counter saturates with a sticky "past end" flag. Any further accepted byte sets DL_OVF=1 and causes no ROM_WE.
- DL_DATA is sampled only on an accepted cycle.

## Timing
- Reset values: DL_READY=0, ROM_AD=0, ROM_DI=0, ROM_WE=0, DL_DONE=0, DL_OVF=0, DL_SUM=0, state IDLE.
- Byte accepted at edge t → ROM_WE/ROM_AD/ROM_DI valid during cycle t+1 → DL_READY high again in cycle t+2. Maximum throughput is 1 byte per 2 clocks.
- DL_READY is a registered output and never depends combinationally on DL_VALID.
- DL_EN dropping during WRITE: the pending write completes, then the state goes to DONE. No byte is lost or duplicated.
- DL_EN dropping and rising again in the same session: it restarts from address 0.
- Reset asserted mid-write: ROM_WE drops immediately (asynchronously). The partial session is abandoned.

## Configuration
- DL_CHECKSUM_EN defined: DL_SUM = 16-bit wrapping sum of every accepted byte in the session, including unmapped and overflow bytes. It updates in the WRITE cycle.
- DL_CHECKSUM_EN undefined: DL_SUM is tied to 16'h0000 and no adder is built.

## Test plan
- Reset, then DL_EN 0→1 and stream 0x11,0x22,0x33 with VALID held high:
  - ROM_WE=4'b0001 at offsets 0,1,2;
  - DL_READY toggles 1,0,1,0;
  - with the checksum enabled, DL_SUM=0x0066.
- Download starting at address 0x4000 (region 1 base): bytes land with ROM_WE=4'b0010 and ROM_AD=0.
- Gap 0x8000 with the default params: byte accepted, ROM_WE=0, counter advances.
- AW=4 with 17 bytes: the 16th byte writes at 0xF, and the 17th sets DL_OVF=1 with no write.
- DL_EN low in the cycle after acceptance: the write still occurs, DL_DONE=1 next cycle, and DL_READY stays 0.
- RST_N pulse mid-WRITE: ROM_WE=0 at once, all outputs return to their reset values, and the next session starts at address 0.
